// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin sharing of one SPI serializer between NUM_CH
// transmit FIFOs. One chip select is driven per channel, with setup and hold
// time around each burst. The serializer-side FIFO signals are gated so the
// serializer can only start while a channel holds the grant.
module spi_tx_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH-1:0]            ch_full,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_read_data,
  output logic [NUM_CH-1:0]            ch_read_en,
  output logic                         ser_empty,
  output logic                         ser_full,
  output logic [DATA_WIDTH-1:0]        ser_read_data,
  input  logic                         ser_read_en,
  input  logic                         ser_done,
  output logic [NUM_CH-1:0]            cs_n,
  output logic [$clog2(NUM_CH)-1:0]    grant_ch,
  output logic                         busy,
  output logic                         xfer_done
);

  localparam int CW = $clog2(NUM_CH);
  localparam int WW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state;
  logic [CW-1:0]       rr_ptr;
  logic [WW-1:0]       word_cnt;
  logic [3:0]          timer;
  logic [NUM_CH-1:0]   req;
  logic                found;
  logic [CW-1:0]       pick;
  logic                burst_open;
  logic [DATA_WIDTH-1:0] ch_word [NUM_CH];

  assign req = ch_enable & ~ch_empty;

  // Unpack the flat read-data bus and build the per-channel pop strobes.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_word[gi]    = ch_read_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign ch_read_en[gi] = ser_read_en & (state == XFER) & (grant_ch == CW'(gi));
  end

  // Round-robin pick: first requesting channel at or after rr_ptr, with wrap.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  assign burst_open = (state == XFER) && (word_cnt < WW'(BURST_LEN));
  assign busy       = (state != IDLE);

  // Serializer only sees the granted FIFO while the burst still has room.
  always_comb begin
    ser_empty     = 1'b1;
    ser_full      = 1'b0;
    ser_read_data = '0;
    if (burst_open) begin
      ser_empty     = ch_empty[grant_ch];
      ser_full      = ch_full[grant_ch];
      ser_read_data = ch_word[grant_ch];
    end
  end

  // Arbitration FSM with registered chip selects and end-of-burst pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_ch  <= '0;
      word_cnt  <= '0;
      timer     <= '0;
      cs_n      <= '1;
      xfer_done <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_ch <= pick;
            timer    <= 4'(CS_SETUP);
            cs_n     <= ~(NUM_CH'(1) << pick);
            state    <= SETUP;
          end
        end
        SETUP: begin
          timer <= timer - 4'd1;
          if (timer == 4'd1) begin
            word_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (ser_read_en) begin
            word_cnt <= word_cnt + 1'b1;
          end else if (ser_done) begin
            if (word_cnt == WW'(BURST_LEN) || ch_empty[grant_ch]) begin
              timer <= 4'(CS_HOLD);
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          timer <= timer - 4'd1;
          if (timer == 4'd1) begin
            cs_n      <= '1;
            xfer_done <= 1'b1;
            rr_ptr    <= (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: directed and randomized bursts through FIFO models and a
// small serializer model, checked against a round-robin reference schedule.
`timescale 1ns/1ps
module tb_spi_tx_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DW        = 8;
  localparam int BURST_LEN = 4;
  localparam int CS_SETUP  = 2;
  localparam int CS_HOLD   = 2;
  localparam int DEPTH     = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NUM_CH-1:0]      ch_enable = '0;
  logic [NUM_CH-1:0]      ch_empty = '1;
  logic [NUM_CH-1:0]      ch_full = '0;
  logic [NUM_CH*DW-1:0]   ch_read_data = '0;
  logic [NUM_CH-1:0]      ch_read_en;
  logic                   ser_empty;
  logic                   ser_full;
  logic [DW-1:0]          ser_read_data;
  logic                   ser_read_en = 1'b0;
  logic                   ser_done = 1'b0;
  logic [NUM_CH-1:0]      cs_n;
  logic [$clog2(NUM_CH)-1:0] grant_ch;
  logic                   busy;
  logic                   xfer_done;

  always #5 clk = ~clk;

  spi_tx_arbiter #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .BURST_LEN(BURST_LEN),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .ch_enable(ch_enable), .ch_empty(ch_empty),
    .ch_full(ch_full), .ch_read_data(ch_read_data), .ch_read_en(ch_read_en),
    .ser_empty(ser_empty), .ser_full(ser_full), .ser_read_data(ser_read_data),
    .ser_read_en(ser_read_en), .ser_done(ser_done), .cs_n(cs_n),
    .grant_ch(grant_ch), .busy(busy), .xfer_done(xfer_done)
  );

  int total = 0;
  int bad   = 0;

  // FIFO contents
  logic [DW-1:0] mem [NUM_CH][32];
  int head  [NUM_CH];
  int count [NUM_CH];

  // reference schedule
  int            exp_ch[$];
  logic [DW-1:0] exp_data[$];
  int            exp_bch[$];
  int            exp_blen[$];
  int            exp_nbursts;

  // observation state
  int  cur_bch, cur_blen;
  bit  prev_high, last_done;
  int  low_cnt, hold_cnt, pops_burst, run_pops, bursts_seen;
  logic [NUM_CH-1:0] pend_pop;

  // serializer model
  bit ser_busy;
  int ser_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int low_idx(input logic [NUM_CH-1:0] v);
    low_idx = NUM_CH;
    for (int i = NUM_CH - 1; i >= 0; i--) if (!v[i]) low_idx = i;
  endfunction

  task automatic clear_fifos();
    for (int i = 0; i < NUM_CH; i++) begin
      head[i]  = 0;
      count[i] = 0;
    end
  endtask

  task automatic push(input int c, input logic [DW-1:0] d);
    mem[c][head[c] + count[c]] = d;
    count[c]++;
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_empty[i] = (count[i] == 0);
      ch_full[i]  = (count[i] >= DEPTH);
      ch_read_data[i*DW +: DW] = (count[i] > 0) ? mem[i][head[i]] : '0;
    end
  endtask

  // Reference: round-robin from channel 0, each grant takes min(BURST_LEN, words left).
  task automatic build_expect(input logic [NUM_CH-1:0] en);
    int cnt [NUM_CH];
    int hd  [NUM_CH];
    int rr, c, n;
    rr = 0;
    exp_nbursts = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt[i] = count[i];
      hd[i]  = head[i];
    end
    forever begin
      c = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int j;
        j = (rr + k) % NUM_CH;
        if (c < 0 && en[j] && cnt[j] > 0) c = j;
      end
      if (c < 0) break;
      n = (cnt[c] < BURST_LEN) ? cnt[c] : BURST_LEN;
      exp_bch.push_back(c);
      exp_blen.push_back(n);
      for (int k = 0; k < n; k++) begin
        exp_ch.push_back(c);
        exp_data.push_back(mem[c][hd[c] + k]);
      end
      hd[c]  += n;
      cnt[c] -= n;
      rr = (c + 1) % NUM_CH;
      exp_nbursts++;
    end
  endtask

  task automatic ser_step();
    ser_read_en = 1'b0;
    ser_done    = 1'b0;
    if (ser_busy) begin
      ser_cnt--;
      if (ser_cnt <= 0) begin
        ser_done = 1'b1;
        ser_busy = 1'b0;
      end
    end else if (ser_empty === 1'b0) begin
      ser_read_en = 1'b1;
      ser_busy    = 1'b1;
      ser_cnt     = $urandom_range(1, 3);
    end
  endtask

  task automatic observe();
    bit high;
    int ch;
    high = (cs_n == '1);
    check("busy_vs_cs", busy, !high);
    check("cs_onehot", $countones(~cs_n) <= 1, 1);
    if (high) begin
      check("gate_idle", {ser_empty, ser_full, ser_read_data, ch_read_en},
            {1'b1, 1'b0, {DW{1'b0}}, {NUM_CH{1'b0}}});
      if (!prev_high) begin
        check("hold_len", hold_cnt, CS_HOLD);
        check("burst_len", pops_burst, cur_blen);
        check("xfer_done_pulse", xfer_done, 1);
        bursts_seen++;
      end else begin
        check("xfer_done_idle", xfer_done, 0);
      end
    end else begin
      if (prev_high) begin
        ch = low_idx(cs_n);
        if (exp_bch.size() == 0) begin
          check("unexpected_grant", ch, NUM_CH);
          cur_bch = ch;
          cur_blen = 0;
        end else begin
          cur_bch  = exp_bch.pop_front();
          cur_blen = exp_blen.pop_front();
          check("grant_order", ch, cur_bch);
        end
        check("grant_ch", grant_ch, ch);
        low_cnt = 0; pops_burst = 0; hold_cnt = 0; last_done = 0;
      end
      if (ch_read_en != '0) begin
        ch = low_idx(~ch_read_en);
        check("pop_onehot", $countones(ch_read_en), 1);
        check("pop_on_selected", ch, low_idx(cs_n));
        if (pops_burst == 0) check("setup_len", low_cnt, CS_SETUP);
        if (exp_ch.size() == 0) begin
          check("unexpected_pop", ch, NUM_CH);
        end else begin
          check("pop_ch", ch, exp_ch.pop_front());
          check("pop_data", ser_read_data, exp_data.pop_front());
        end
        check("pop_full", ser_full, count[ch] >= DEPTH);
        $display("pop ch=%0d data=%02h burst_word=%0d", ch, ser_read_data, pops_burst + 1);
        pend_pop[ch] = 1'b1;
        pops_burst++;
        run_pops++;
        last_done = 0;
      end else if (pops_burst == BURST_LEN) begin
        check("limit_gate", ser_empty, 1);
      end
      if (ser_done) begin
        last_done = 1;
        hold_cnt  = 0;
      end else if (last_done) begin
        hold_cnt++;
      end
      low_cnt++;
    end
    prev_high = high;
  endtask

  task automatic step(output bit aborted, input int abort_pops);
    aborted = 1'b0;
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pend_pop[i] && count[i] > 0) begin
        head[i]++;
        count[i]--;
      end
    end
    pend_pop = '0;
    if (abort_pops > 0 && run_pops == abort_pops) begin
      rst = 1'b0;
      ser_read_en = 1'b0;
      ser_done = 1'b0;
      ser_busy = 1'b0;
      #1;
      check("abort_cs_n", cs_n, {NUM_CH{1'b1}});
      check("abort_ser_empty", ser_empty, 1);
      check("abort_busy", busy, 0);
      aborted = 1'b1;
      return;
    end
    drive_fifo();
    #1;
    ser_step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ser_read_en = 1'b0;
    ser_done = 1'b0;
    ser_busy = 1'b0;
    ser_cnt = 0;
    exp_ch.delete(); exp_data.delete(); exp_bch.delete(); exp_blen.delete();
    prev_high = 1; last_done = 0; pend_pop = '0;
    bursts_seen = 0; cur_blen = 0; cur_bch = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive_fifo();
  endtask

  task automatic run_test(input string name, input logic [NUM_CH-1:0] en, input int abort_pops);
    bit ab;
    int tail;
    ab = 1'b0;
    tail = 0;
    ch_enable = en;
    run_pops = 0;
    build_expect(en);
    drive_fifo();
    #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step(ab, abort_pops);
      if (ab) break;
      if (exp_bch.size() == 0 && prev_high) tail++;
      if (tail >= 8) break;
    end
    if (!ab) begin
      check("finished_in_budget", tail >= 8, 1);
      check("pops_left", exp_ch.size(), 0);
      check("burst_count", bursts_seen, exp_nbursts);
    end
    $display("test %s: pops=%0d bursts=%0d", name, run_pops, bursts_seen);
  endtask

  initial begin
    // reset values, with stray serializer strobes present during reset
    clear_fifos();
    push(0, 8'h11);
    drive_fifo();
    ch_enable = '1;
    ser_read_en = 1'b1;
    ser_done = 1'b1;
    #12;
    check("rst_cs_n", cs_n, {NUM_CH{1'b1}});
    check("rst_busy", busy, 0);
    check("rst_xfer_done", xfer_done, 0);
    check("rst_ch_read_en", ch_read_en, 0);
    check("rst_ser_empty", ser_empty, 1);
    check("rst_ser_full", ser_full, 0);
    check("rst_ser_read_data", ser_read_data, 0);
    check("rst_grant_ch", grant_ch, 0);

    // strobes while IDLE with nothing to send are ignored
    clear_fifos();
    do_reset();
    ser_read_en = 1'b1;
    ser_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stray_ch_read_en", ch_read_en, 0);
    check("stray_busy", busy, 0);
    ser_read_en = 1'b0;
    ser_done = 1'b0;

    // single channel
    clear_fifos();
    push(0, 8'hA5); push(0, 8'h3C); push(0, 8'hFF);
    do_reset();
    run_test("single", 4'b0001, 0);

    // round robin, one word each
    clear_fifos();
    for (int i = 0; i < NUM_CH; i++) push(i, 8'(8'h40 + i));
    do_reset();
    run_test("round_robin", 4'b1111, 0);

    // burst limit
    clear_fifos();
    for (int k = 0; k < 6; k++) push(1, 8'(8'h10 + k));
    push(2, 8'h77);
    do_reset();
    run_test("burst_limit", 4'b1111, 0);

    // mask
    clear_fifos();
    for (int i = 0; i < NUM_CH; i++)
      for (int k = 0; k < 2 + i; k++) push(i, 8'($urandom));
    do_reset();
    run_test("mask", 4'b0101, 0);

    // reset in the middle of a burst, then restart from channel 0
    clear_fifos();
    for (int k = 0; k < 4; k++) push(0, 8'(8'hC0 + k));
    push(1, 8'h5A);
    do_reset();
    run_test("abort", 4'b0001, 2);
    push(3, 8'h99);
    do_reset();
    run_test("after_abort", 4'b1111, 0);

    // randomized mixes
    for (int it = 0; it < 5; it++) begin
      clear_fifos();
      for (int i = 0; i < NUM_CH; i++) begin
        int n;
        n = $urandom_range(0, DEPTH);
        for (int k = 0; k < n; k++) push(i, 8'($urandom));
      end
      do_reset();
      run_test("random", 4'($urandom_range(1, 15)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
